// File: rtl/conv_phase_sequencer_pkg.sv
// Shared definitions for the convolution phase sequencer and the phase mux:
// state codes, command codes, status message codes and small helpers.
package conv_phase_sequencer_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [3:0] {
    ST_WAIT_FOR_CC      = 4'd0,
    ST_INIT_LOAD_OFM    = 4'd1,
    ST_LOAD_OFM         = 4'd2,
    ST_INIT_LOAD_IFM    = 4'd3,
    ST_LOAD_IFM         = 4'd4,
    ST_INIT_LOAD_WEIGHT = 4'd5,
    ST_LOAD_WEIGHT      = 4'd6,
    ST_INIT_CONV        = 4'd7,
    ST_CONV             = 4'd8,
    ST_INIT_WRITE_BACK  = 4'd9,
    ST_WRITE_BACK       = 4'd10,
    ST_DEBUG            = 4'd11
  } state_e;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_PING  = 8'h02;
  localparam logic [7:0] CMD_ACK   = 8'h03;
  localparam logic [7:0] CMD_ABORT = 8'h04;

  localparam logic [7:0] MSG_NONE         = 8'h00;
  localparam logic [7:0] MSG_DONE         = 8'h80;
  localparam logic [7:0] MSG_PING         = 8'hA5;
  localparam logic [7:0] MSG_TIMEOUT_BASE = 8'hE0;
  localparam logic [7:0] MSG_ABORT        = 8'hEF;

  localparam logic [2:0] PH_OFM  = 3'd1;
  localparam logic [2:0] PH_IFM  = 3'd2;
  localparam logic [2:0] PH_WT   = 3'd3;
  localparam logic [2:0] PH_CONV = 3'd4;
  localparam logic [2:0] PH_WB   = 3'd5;

  // Timeout status code carries the hung phase in its low bits.
  function automatic logic [7:0] timeout_msg(input logic [2:0] phase);
    return MSG_TIMEOUT_BASE | {5'b00000, phase};
  endfunction

  // Wait states are the ones that block on a done pulse and run the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_LOAD_OFM) || (s == ST_LOAD_IFM) || (s == ST_LOAD_WEIGHT) ||
           (s == ST_CONV) || (s == ST_WRITE_BACK);
  endfunction

endpackage

// File: rtl/conv_phase_sequencer_phase_watchdog.sv
// Watchdog for a single wait phase: saturating cycle counter that flags
// expiry on the last allowed cycle. TIMEOUT_CYCLES of 0 disables it.
module phase_watchdog #(
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT     = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

  logic [TIMEOUT_W-1:0] timer_r;

  // Cycle counter: cleared outside wait phases, counts up and saturates inside them.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= {TIMEOUT_W{1'b0}};
    end else if (clear) begin
      timer_r <= {TIMEOUT_W{1'b0}};
    end else if (enable && (timer_r != TIMER_MAX)) begin
      timer_r <= timer_r + TIMEOUT_W'(1'b1);
    end else begin
      timer_r <= timer_r;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (timer_r == LIMIT);

endmodule

// File: rtl/conv_phase_sequencer.sv
// Phase controller for the convolution accelerator: sequences the per-tile
// load/conv/write-back phases, handles control-core commands and traps hung
// phases via a watchdog.
module conv_phase_sequencer
  import conv_phase_sequencer_pkg::*;
#(
  parameter int NUM_STATES_W   = STATE_W,
  parameter int TILE_W         = 8,
  parameter int TIMEOUT_W      = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cc_cmd_valid,
  input  logic [7:0]              cc_cmd,
  input  logic [TILE_W-1:0]       cfg_num_tiles,
  input  logic                    ol_done,
  input  logic                    il_done,
  input  logic                    wl_done,
  input  logic                    conv_done,
  input  logic                    ow_done,
  output logic [NUM_STATES_W-1:0] state,
  output logic [7:0]              msg,
  output logic [TILE_W-1:0]       tile_idx,
  output logic                    busy
);

  state_e              state_r, next_state_s;
  logic [7:0]          msg_r, next_msg_s;
  logic [TILE_W-1:0]   tile_idx_r, next_tile_s;
  logic [TILE_W-1:0]   tiles_r, next_tiles_s;
  logic                busy_r;
  logic                wait_s, expired_s;
  logic                start_s, ping_s, ack_s, abort_s, last_tile_s;

  assign start_s     = cc_cmd_valid && (cc_cmd == CMD_START);
  assign ping_s      = cc_cmd_valid && (cc_cmd == CMD_PING);
  assign ack_s       = cc_cmd_valid && (cc_cmd == CMD_ACK);
  assign abort_s     = cc_cmd_valid && (cc_cmd == CMD_ABORT);
  assign wait_s      = is_wait_state(state_r);
  assign last_tile_s = (tile_idx_r == (tiles_r - TILE_W'(1'b1)));

  phase_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!wait_s),
    .enable  (wait_s),
    .expired (expired_s)
  );

  // Next-state logic; abort outranks done, which outranks watchdog expiry.
  always_comb begin
    next_state_s = state_r;
    next_msg_s   = msg_r;
    next_tile_s  = tile_idx_r;
    next_tiles_s = tiles_r;
    case (state_r)
      ST_WAIT_FOR_CC: begin
        if (start_s) begin
          next_tiles_s = (cfg_num_tiles == {TILE_W{1'b0}}) ? TILE_W'(1'b1) : cfg_num_tiles;
          next_tile_s  = {TILE_W{1'b0}};
          next_msg_s   = MSG_NONE;
          next_state_s = ST_INIT_LOAD_OFM;
        end else if (ping_s) begin
          next_msg_s   = MSG_PING;
          next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_WAIT_FOR_CC;
        end
      end
      ST_INIT_LOAD_OFM, ST_INIT_LOAD_IFM, ST_INIT_LOAD_WEIGHT, ST_INIT_CONV, ST_INIT_WRITE_BACK: begin
        if (abort_s) begin
          next_msg_s   = MSG_ABORT;
          next_state_s = ST_DEBUG;
        end else begin
          // Each INIT code is immediately followed by its wait code.
          next_state_s = state_e'(state_r + 4'd1);
        end
      end
      ST_LOAD_OFM: begin
        if (abort_s) begin
          next_msg_s = MSG_ABORT;  next_state_s = ST_DEBUG;
        end else if (ol_done) begin
          next_state_s = ST_INIT_LOAD_IFM;
        end else if (expired_s) begin
          next_msg_s = timeout_msg(PH_OFM);  next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_LOAD_OFM;
        end
      end
      ST_LOAD_IFM: begin
        if (abort_s) begin
          next_msg_s = MSG_ABORT;  next_state_s = ST_DEBUG;
        end else if (il_done) begin
          next_state_s = ST_INIT_LOAD_WEIGHT;
        end else if (expired_s) begin
          next_msg_s = timeout_msg(PH_IFM);  next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_LOAD_IFM;
        end
      end
      ST_LOAD_WEIGHT: begin
        if (abort_s) begin
          next_msg_s = MSG_ABORT;  next_state_s = ST_DEBUG;
        end else if (wl_done) begin
          next_state_s = ST_INIT_CONV;
        end else if (expired_s) begin
          next_msg_s = timeout_msg(PH_WT);  next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_LOAD_WEIGHT;
        end
      end
      ST_CONV: begin
        if (abort_s) begin
          next_msg_s = MSG_ABORT;  next_state_s = ST_DEBUG;
        end else if (conv_done) begin
          next_state_s = ST_INIT_WRITE_BACK;
        end else if (expired_s) begin
          next_msg_s = timeout_msg(PH_CONV);  next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_CONV;
        end
      end
      ST_WRITE_BACK: begin
        if (abort_s) begin
          next_msg_s = MSG_ABORT;  next_state_s = ST_DEBUG;
        end else if (ow_done) begin
          if (last_tile_s) begin
            next_msg_s   = MSG_DONE;
            next_state_s = ST_DEBUG;
          end else begin
            next_tile_s  = tile_idx_r + TILE_W'(1'b1);
            next_state_s = ST_INIT_LOAD_OFM;
          end
        end else if (expired_s) begin
          next_msg_s = timeout_msg(PH_WB);  next_state_s = ST_DEBUG;
        end else begin
          next_state_s = ST_WRITE_BACK;
        end
      end
      ST_DEBUG: begin
        if (ack_s) begin
          next_msg_s   = MSG_NONE;
          next_state_s = ST_WAIT_FOR_CC;
        end else begin
          next_state_s = ST_DEBUG;
        end
      end
      default: begin
        next_state_s = ST_WAIT_FOR_CC;
      end
    endcase
  end

  // Registered state and outputs; busy is derived from the next state so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_WAIT_FOR_CC;
      msg_r      <= MSG_NONE;
      tile_idx_r <= {TILE_W{1'b0}};
      tiles_r    <= TILE_W'(1'b1);
      busy_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      msg_r      <= next_msg_s;
      tile_idx_r <= next_tile_s;
      tiles_r    <= next_tiles_s;
      busy_r     <= (next_state_s != ST_WAIT_FOR_CC) && (next_state_s != ST_DEBUG);
    end
  end

  assign state    = NUM_STATES_W'(state_r);
  assign msg      = msg_r;
  assign tile_idx = tile_idx_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Self-checking bench for conv_phase_sequencer: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_conv_phase_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cc_cmd_valid = 1'b0;
  logic [7:0] cc_cmd = 8'h00;
  logic [7:0] cfg_num_tiles = 8'h00;
  logic [4:0] auto_done = 5'b0;
  logic [4:0] force_done = 5'b0;
  logic [4:0] done_v;
  logic       ol_done, il_done, wl_done, conv_done, ow_done;
  logic [3:0] state;
  logic [7:0] msg;
  logic [7:0] tile_idx;
  logic       busy;

  assign done_v    = auto_done | force_done;
  assign ol_done   = done_v[0];
  assign il_done   = done_v[1];
  assign wl_done   = done_v[2];
  assign conv_done = done_v[3];
  assign ow_done   = done_v[4];

  conv_phase_sequencer #(.NUM_STATES_W(4), .TILE_W(8), .TIMEOUT_W(24), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cc_cmd_valid(cc_cmd_valid), .cc_cmd(cc_cmd),
    .cfg_num_tiles(cfg_num_tiles), .ol_done(ol_done), .il_done(il_done), .wl_done(wl_done),
    .conv_done(conv_done), .ow_done(ow_done), .state(state), .msg(msg), .tile_idx(tile_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase position (0 idle, odd = init, even 2..10 = waiting on phase n/2, 11 debug)
  int         m_state = 0;
  int         m_wait = 0;
  int         m_tile = 0;
  int         m_tiles = 1;
  logic [7:0] m_msg = 8'h00;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  int         auto_mode = 0;
  logic [4:0] withhold = 5'b0;
  int         trace_q[$];
  bit         trace_en = 1'b0;
  logic [3:0] prev_state = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit is_cmd;
    int ph;
    is_cmd = cc_cmd_valid;
    if (reset) begin
      m_state = 0; m_msg = 8'h00; m_tile = 0; m_tiles = 1; m_wait = 0;
    end else if (m_state == 0) begin
      if (is_cmd && cc_cmd == 8'h01) begin
        m_tiles = (cfg_num_tiles == 8'd0) ? 1 : int'(cfg_num_tiles);
        m_tile = 0; m_msg = 8'h00; m_state = 1;
      end else if (is_cmd && cc_cmd == 8'h02) begin
        m_msg = 8'hA5; m_state = 11;
      end
    end else if (m_state == 11) begin
      if (is_cmd && cc_cmd == 8'h03) begin
        m_msg = 8'h00; m_state = 0;
      end
    end else if (is_cmd && cc_cmd == 8'h04) begin
      m_msg = 8'hEF; m_state = 11;
    end else if (m_state % 2 == 1) begin
      m_state = m_state + 1; m_wait = 0;
    end else begin
      ph = m_state / 2;
      if (done_v[ph-1]) begin
        if (ph < 5) m_state = m_state + 1;
        else if (m_tile == m_tiles - 1) begin m_msg = 8'h80; m_state = 11; end
        else begin m_tile = m_tile + 1; m_state = 1; end
      end else if (m_wait == TO - 1) begin
        m_msg = 8'hE0 + 8'(ph); m_state = 11;
      end else begin
        m_wait = m_wait + 1;
      end
    end
  endtask

  // Model update at each active edge, then per-cycle comparison just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (chk_en) begin
        check("state", 32'(state), 32'(m_state));
        check("msg", 32'(msg), 32'(m_msg));
        check("tile_idx", 32'(tile_idx), 32'(m_tile));
        check("busy", 32'(busy), 32'((m_state != 0) && (m_state != 11)));
      end
      if (trace_en && state != prev_state) trace_q.push_back(int'(state));
      prev_state = state;
    end
  end

  // Done-pulse responder: fixed 5-cycle latency (mode 1) or random pulses (mode 2).
  always @(negedge clk) begin
    auto_done = 5'b0;
    if (auto_mode == 1) begin
      if (m_state >= 2 && m_state <= 10 && m_state % 2 == 0 && !withhold[m_state/2-1] && m_wait == 4)
        auto_done[m_state/2-1] = 1'b1;
    end else if (auto_mode == 2) begin
      for (int i = 0; i < 5; i++) auto_done[i] = ($urandom_range(0, 15) == 0);
      if (m_state >= 2 && m_state <= 10 && m_state % 2 == 0)
        auto_done[m_state/2-1] = ($urandom_range(0, 5) == 0);
    end
  end

  task automatic send_cmd(input logic [7:0] c);
    cc_cmd_valid = 1'b1; cc_cmd = c;
    @(negedge clk);
    cc_cmd_valid = 1'b0; cc_cmd = 8'h00;
  endtask

  task automatic wait_state(input int s, input int budget);
    int k;
    for (k = 0; k < budget && m_state != s; k++) @(negedge clk);
    if (m_state != s) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_state: state %0d not reached within %0d cycles", s, budget);
    end
  endtask

  initial begin
    int k;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_msg", 32'(msg), 32'd0);
    check("rst_tile", 32'(tile_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two tiles, every done 5 cycles after wait-state entry.
    auto_mode = 1; withhold = 5'b0; cfg_num_tiles = 8'd2;
    trace_q.delete(); trace_en = 1'b1;
    send_cmd(8'h01);
    wait_state(11, 400);
    trace_en = 1'b0;
    check("two_tile_state", 32'(state), 32'd11);
    check("two_tile_msg", 32'(msg), 32'h80);
    check("two_tile_idx", 32'(tile_idx), 32'd1);
    check("two_tile_busy", 32'(busy), 32'd0);
    check("two_tile_trace_len", 32'(trace_q.size()), 32'd21);
    if (trace_q.size() == 21) begin
      for (int i = 0; i < 20; i++) check("two_tile_trace", 32'(trace_q[i]), 32'((i % 10) + 1));
      check("two_tile_trace_end", 32'(trace_q[20]), 32'd11);
    end
    send_cmd(8'h03);
    check("ack_state", 32'(state), 32'd0);
    check("ack_msg", 32'(msg), 32'd0);

    // Zero tiles clamps to one.
    cfg_num_tiles = 8'd0; trace_q.delete(); trace_en = 1'b1;
    send_cmd(8'h01);
    wait_state(11, 200);
    trace_en = 1'b0;
    check("zero_tile_msg", 32'(msg), 32'h80);
    check("zero_tile_idx", 32'(tile_idx), 32'd0);
    check("zero_tile_trace_len", 32'(trace_q.size()), 32'd11);
    send_cmd(8'h03);

    // Watchdog on a withheld conv_done.
    withhold = 5'b01000; cfg_num_tiles = 8'd1;
    send_cmd(8'h01);
    wait_state(8, 200);
    for (k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("wd_still_conv", 32'(state), 32'd8);
    end
    check("wd_state", 32'(state), 32'd11);
    check("wd_msg", 32'(msg), 32'hE4);
    send_cmd(8'h03);
    check("wd_ack_state", 32'(state), 32'd0);
    check("wd_ack_msg", 32'(msg), 32'd0);

    // ABORT beats a simultaneous ol_done.
    withhold = 5'b00001;
    send_cmd(8'h01);
    wait_state(2, 50);
    cc_cmd_valid = 1'b1; cc_cmd = 8'h04; force_done = 5'b00001;
    @(negedge clk);
    cc_cmd_valid = 1'b0; cc_cmd = 8'h00; force_done = 5'b0;
    check("abort_state", 32'(state), 32'd11);
    check("abort_msg", 32'(msg), 32'hEF);
    send_cmd(8'h03);

    // Stray conv_done during LOAD_IFM is ignored.
    withhold = 5'b00010;
    send_cmd(8'h01);
    wait_state(4, 100);
    force_done = 5'b01000;
    @(negedge clk);
    force_done = 5'b0;
    check("stray_state", 32'(state), 32'd4);
    send_cmd(8'h04);
    check("stray_abort_msg", 32'(msg), 32'hEF);
    send_cmd(8'h03);
    withhold = 5'b0;

    // Reset in WRITE_BACK of tile 3.
    cfg_num_tiles = 8'd5;
    send_cmd(8'h01);
    for (k = 0; k < 600 && !(m_state == 10 && m_tile == 3); k++) @(negedge clk);
    check("reach_wb_tile3", 32'(tile_idx), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_tile", 32'(tile_idx), 32'd0);
    check("mid_rst_msg", 32'(msg), 32'd0);
    send_cmd(8'h02);
    check("ping_state", 32'(state), 32'd11);
    check("ping_msg", 32'(msg), 32'hA5);
    send_cmd(8'h01);
    check("debug_start_state", 32'(state), 32'd11);
    check("debug_start_msg", 32'(msg), 32'hA5);
    send_cmd(8'h03);

    // Randomized run against the model.
    auto_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 15);
      reset = ($urandom_range(0, 499) == 0);
      cfg_num_tiles = 8'($urandom_range(0, 3));
      if (m_state == 0 && r < 4) begin
        cc_cmd_valid = 1'b1; cc_cmd = 8'h01;
      end else if (m_state == 11 && r < 3) begin
        cc_cmd_valid = 1'b1; cc_cmd = 8'h03;
      end else if (r == 15) begin
        cc_cmd_valid = 1'b1; cc_cmd = 8'($urandom_range(0, 6));
      end else begin
        cc_cmd_valid = 1'b0; cc_cmd = 8'h00;
      end
      @(negedge clk);
    end
    cc_cmd_valid = 1'b0; reset = 1'b0; auto_mode = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
